uart_rx: RTL and testbench

//  8N1 UART receiver, the receive-side counterpart of the UART transmitter.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and
// baud-rate divisor helpers used by both the receiver and the bit timer.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int DEFAULT_CLOCK_HZ = 10_000_000;
  localparam int DEFAULT_BAUD     = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Rounded divisor so that the bit period error stays below half a clock.
  function automatic int calc_clks_per_bit(input int clock_hz, input int baud);
    return (clock_hz + baud / 2) / baud;
  endfunction

  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..terminal, raises tick on the terminal count and
// wraps to zero. A clear restarts the period from zero on the next cycle.
module uart_bit_timer #(
  parameter int WIDTH = 7
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] terminal,
  output logic             tick
);

  logic [WIDTH-1:0] count_q;

  assign tick = (count_q == terminal);

  // Free-running period counter, restarted by clear or by reaching terminal.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else if (clear || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, finds the start bit,
// samples each bit at its middle and presents the byte with a one-cycle strobe.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line idle, waiting for a low level on the synchronized input
// START | half a bit into the start bit; low confirms, high is a glitch
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; high delivers the byte, low is a frame error
// BREAK | line stuck low after a frame error, wait for it to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ = DEFAULT_CLOCK_HZ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Rx_i,
  output logic [DATA_BITS-1:0] Data_o,
  output logic                 Done_o,
  output logic                 Busy_o,
  output logic                 FrameError_o
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_HZ, BAUD);
  localparam int HALF_BIT     = calc_half_bit(CLKS_PER_BIT);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] TC_BIT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TC_HALF  = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_meta;
  logic rx_sync;

  rx_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  logic             timer_clear;
  logic [CNT_W-1:0] timer_term;
  logic             tick;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= Rx_i;
      rx_sync <= rx_meta;
    end
  end

  // The start state only waits half a bit so later ticks land mid-bit.
  assign timer_term = (state_q == ST_START) ? TC_HALF : TC_BIT;

  uart_bit_timer #(
    .WIDTH (CNT_W)
  ) u_bit_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (timer_clear),
    .terminal (timer_term),
    .tick     (tick)
  );

  // State and datapath registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      ST_IDLE: begin
        // Level detect: a line that is low out of reset also starts a frame.
        if (!rx_sync) begin
          state_d = ST_START;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          if (!rx_sync) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        // Returning to IDLE at mid-stop lets a back-to-back start bit be caught.
        if (tick) begin
          if (rx_sync) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        if (rx_sync) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    timer_clear = (state_d != state_q);
  end

  assign Data_o       = data_q;
  assign Done_o       = done_q;
  assign Busy_o       = busy_q;
  assign FrameError_o = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial TX model drives Rx_i, expected
// bytes and frame errors are queued as frames are sent and compared by a
// monitor whenever the receiver pulses Done_o or FrameError_o.
module tb_uart_rx;

  localparam int CLK_HALF     = 50;     // 100-unit period stands for 10 MHz
  localparam int CLKS_PER_BIT = 87;
  localparam int BIT_NOM      = 8681;   // 115200 baud in the same units
  localparam int BIT_FAST     = 8428;   // +3% baud
  localparam int BIT_SLOW     = 8949;   // -3% baud

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Rx_i  = 1'b1;
  logic [7:0] Data_o;
  logic       Done_o;
  logic       Busy_o;
  logic       FrameError_o;

  uart_rx #(
    .CLOCK_HZ (10_000_000),
    .BAUD     (115_200)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Rx_i         (Rx_i),
    .Data_o       (Data_o),
    .Done_o       (Done_o),
    .Busy_o       (Busy_o),
    .FrameError_o (FrameError_o)
  );

  always #CLK_HALF Clock = ~Clock;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] last_data = 8'h00;
  logic       prev_done = 1'b0;
  logic       prev_fe   = 1'b0;
  int         checks    = 0;
  int         errors    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    sb_q.push_back('{is_err: 1'b0, data: b});
    last_data = b;
  endtask

  task automatic expect_ferr();
    sb_q.push_back('{is_err: 1'b1, data: last_data});
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_val);
    Rx_i = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      Rx_i = b[i];
      #(bit_t);
    end
    Rx_i = stop_val;
    #(bit_t);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge Clock) begin
    if (Done_o || FrameError_o) begin
      check("exclusive", 32'(Done_o & FrameError_o), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'({Done_o, FrameError_o}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_kind", 32'(FrameError_o), 32'(mon_e.is_err));
        check("data_o", 32'(Data_o), 32'(mon_e.data));
      end
    end
    if (Done_o)       check("done_width", 32'(prev_done), 32'd0);
    if (FrameError_o) check("ferr_width", 32'(prev_fe), 32'd0);
    prev_done <= Done_o;
    prev_fe   <= FrameError_o;
  end

  initial begin
    #(8_000_000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with idle line
    Rx_i  = 1'b1;
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    check("reset_data", 32'(Data_o), 32'd0);
    check("reset_done", 32'(Done_o), 32'd0);
    check("reset_busy", 32'(Busy_o), 32'd0);
    check("reset_ferr", 32'(FrameError_o), 32'd0);
    Reset = 1'b0;
    repeat (200) @(negedge Clock);
    check("idle_busy", 32'(Busy_o), 32'd0);
    check("idle_data", 32'(Data_o), 32'd0);

    // Two frames at nominal baud
    expect_byte(8'h55);
    fork
      send_frame(8'h55, BIT_NOM, 1'b1);
      begin
        repeat (4 * CLKS_PER_BIT) @(negedge Clock);
        check("busy_mid_frame", 32'(Busy_o), 32'd1);
      end
    join
    #(BIT_NOM);
    expect_byte(8'hA3);
    send_frame(8'hA3, BIT_NOM, 1'b1);
    @(negedge Clock);
    check("busy_after_frame", 32'(Busy_o), 32'd0);
    wait_drain(500);

    // Back-to-back frames with no idle bits
    #(BIT_NOM);
    expect_byte(8'h00);
    send_frame(8'h00, BIT_NOM, 1'b1);
    expect_byte(8'hFF);
    send_frame(8'hFF, BIT_NOM, 1'b1);
    expect_byte(8'h81);
    send_frame(8'h81, BIT_NOM, 1'b1);
    wait_drain(500);

    // Short low glitch is rejected
    #(BIT_NOM);
    @(negedge Clock);
    Rx_i = 1'b0;
    repeat (10) @(negedge Clock);
    check("glitch_busy_high", 32'(Busy_o), 32'd1);
    repeat (10) @(negedge Clock);
    Rx_i = 1'b1;
    repeat (100) @(negedge Clock);
    check("glitch_busy_low", 32'(Busy_o), 32'd0);
    check("glitch_data", 32'(Data_o), 32'(last_data));

    // Stop bit low, line held low, then recovery
    #(BIT_NOM);
    expect_ferr();
    send_frame(8'h3C, BIT_NOM, 1'b0);
    #(2 * BIT_NOM);
    check("break_busy", 32'(Busy_o), 32'd1);
    Rx_i = 1'b1;
    repeat (5) @(negedge Clock);
    check("ferr_data_kept", 32'(Data_o), 32'(last_data));
    check("break_exit_busy", 32'(Busy_o), 32'd0);
    wait_drain(500);
    #(BIT_NOM);
    expect_byte(8'h7E);
    send_frame(8'h7E, BIT_NOM, 1'b1);
    wait_drain(500);

    // Reset in the middle of data bit 4
    #(BIT_NOM);
    fork
      send_frame(8'hC3, BIT_NOM, 1'b1);
      begin
        repeat (5 * CLKS_PER_BIT + CLKS_PER_BIT / 2) @(negedge Clock);
        check("busy_before_reset", 32'(Busy_o), 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        check("midreset_data", 32'(Data_o), 32'd0);
        check("midreset_busy", 32'(Busy_o), 32'd0);
        check("midreset_done", 32'(Done_o), 32'd0);
        check("midreset_ferr", 32'(FrameError_o), 32'd0);
      end
    join
    last_data = 8'h00;
    repeat (5) @(negedge Clock);
    Reset = 1'b0;
    #(BIT_NOM);
    expect_byte(8'h12);
    send_frame(8'h12, BIT_NOM, 1'b1);
    wait_drain(500);

    // Baud mismatch of +3% and -3%
    #(BIT_NOM);
    expect_byte(8'h55);
    send_frame(8'h55, BIT_FAST, 1'b1);
    expect_byte(8'hA3);
    send_frame(8'hA3, BIT_FAST, 1'b1);
    wait_drain(500);
    #(BIT_NOM);
    expect_byte(8'h55);
    send_frame(8'h55, BIT_SLOW, 1'b1);
    expect_byte(8'hA3);
    send_frame(8'hA3, BIT_SLOW, 1'b1);
    wait_drain(500);

    repeat (10) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
